// File: rtl/atm_pkg.sv
// Shared opcode, status and FSM encodings for the ATM ledger arbiter.
package atm_pkg;
    localparam logic [1:0] OP_ILLEGAL  = 2'b00;
    localparam logic [1:0] OP_DEPOSIT  = 2'b01;
    localparam logic [1:0] OP_WITHDRAW = 2'b10;
    localparam logic [1:0] OP_BALANCE  = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_NOFUNDS  = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;
    localparam logic [1:0] ST_BADREQ   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request above the pointer,
// wrapping, as both one-hot and index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    always_comb begin
        int  j;
        logic found;
        found = 1'b0;
        o_gnt = '0;
        o_idx = '0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!found && i_req[j]) begin
                found    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
        o_valid = found;
    end
endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared account ledger serving NUM_TERM terminals via round-robin arbitration.
// Define LEDGER_AUDIT_EN to add the txn_count / err_sticky audit outputs.
module atm_ledger_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_TERM = 4,
    parameter int ACCT_W   = 2,
    parameter int AMT_W    = 5,
    parameter int BAL_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_TERM-1:0]        req,
    input  logic [2*NUM_TERM-1:0]      op,
    input  logic [ACCT_W*NUM_TERM-1:0] acct,
    input  logic [AMT_W*NUM_TERM-1:0]  amount,
    output logic [NUM_TERM-1:0]        ack,
    output logic [1:0]                 rsp_status,
    output logic [BAL_W-1:0]           rsp_balance,
    output logic                       busy
`ifdef LEDGER_AUDIT_EN
    ,
    output logic [15:0]                txn_count,
    output logic                       err_sticky
`endif
);
    localparam int IW    = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
    localparam int NACCT = 2 ** ACCT_W;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_g;
    logic [NUM_TERM-1:0] r_gnt;
    logic [1:0]          r_op;
    logic [ACCT_W-1:0]   r_acct;
    logic [AMT_W-1:0]    r_amt;
    logic [BAL_W-1:0]    r_ledger [NACCT];

    logic [NUM_TERM-1:0] w_gnt;
    logic [IW-1:0]       w_idx;
    logic                w_valid;
    logic [BAL_W-1:0]    w_old;
    logic [BAL_W:0]      w_amt_x;
    logic [BAL_W:0]      w_sum;
    logic [BAL_W-1:0]    w_new;
    logic [1:0]          w_status;
    logic                w_wr;

    rr_arbiter #(.N(NUM_TERM), .IW(IW)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign busy = (r_state != S_IDLE);

    // Sums and compares run one bit wider so overflow and shortfall are explicit.
    always_comb begin
        w_old    = r_ledger[r_acct];
        w_amt_x  = (BAL_W+1)'(r_amt);
        w_sum    = {1'b0, w_old} + w_amt_x;
        w_new    = w_old;
        w_status = ST_OK;
        w_wr     = 1'b0;
        unique case (r_op)
            OP_DEPOSIT: begin
                if (r_amt == '0) begin
                    w_status = ST_BADREQ;
                end else if (w_sum[BAL_W]) begin
                    w_status = ST_OVERFLOW;
                end else begin
                    w_new = w_sum[BAL_W-1:0];
                    w_wr  = 1'b1;
                end
            end
            OP_WITHDRAW: begin
                if (r_amt == '0) begin
                    w_status = ST_BADREQ;
                end else if (w_amt_x > {1'b0, w_old}) begin
                    w_status = ST_NOFUNDS;
                end else begin
                    w_new = w_old - w_amt_x[BAL_W-1:0];
                    w_wr  = 1'b1;
                end
            end
            OP_BALANCE: begin
                w_status = ST_OK;
            end
            default: begin
                w_status = ST_BADREQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= IW'(NUM_TERM - 1);
            r_g         <= '0;
            r_gnt       <= '0;
            r_op        <= OP_ILLEGAL;
            r_acct      <= '0;
            r_amt       <= '0;
            ack         <= '0;
            rsp_status  <= ST_OK;
            rsp_balance <= '0;
            for (int i = 0; i < NACCT; i++) begin
                r_ledger[i] <= '0;
            end
`ifdef LEDGER_AUDIT_EN
            txn_count   <= '0;
            err_sticky  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    ack <= '0;
                    if (w_valid) begin
                        r_g     <= w_idx;
                        r_gnt   <= w_gnt;
                        r_op    <= op[w_idx*2 +: 2];
                        r_acct  <= acct[w_idx*ACCT_W +: ACCT_W];
                        r_amt   <= amount[w_idx*AMT_W +: AMT_W];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_wr) begin
                        r_ledger[r_acct] <= w_new;
                    end
                    rsp_status  <= w_status;
                    rsp_balance <= w_new;
                    ack         <= r_gnt;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    ack     <= '0;
                    r_ptr   <= r_g;
                    r_state <= S_IDLE;
`ifdef LEDGER_AUDIT_EN
                    if (rsp_status == ST_OK &&
                        (r_op == OP_DEPOSIT || r_op == OP_WITHDRAW)) begin
                        txn_count <= txn_count + 16'd1;
                    end
                    if (rsp_status != ST_OK) begin
                        err_sticky <= 1'b1;
                    end
`endif
                end
                default: begin
                    ack     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Directed self-checking bench for atm_ledger_arbiter.
// Audit checks are compiled in when LEDGER_AUDIT_EN is defined.
module tb_atm_ledger_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [7:0]  acct;
    logic [19:0] amount;
    logic [3:0]  ack;
    logic [1:0]  rsp_status;
    logic [7:0]  rsp_balance;
    logic        busy;
`ifdef LEDGER_AUDIT_EN
    logic [15:0] txn_count;
    logic        err_sticky;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    atm_ledger_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op          (op),
        .acct        (acct),
        .amount      (amount),
        .ack         (ack),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .busy        (busy)
`ifdef LEDGER_AUDIT_EN
        ,
        .txn_count   (txn_count),
        .err_sticky  (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request; scramble the terminal's inputs and drop req right
    // after grant, since the transaction must complete from latched values.
    task automatic do_txn(input int t, input logic [1:0] o, input int a,
                          input int amt, input logic [1:0] es,
                          input int eb, input string tag);
        int lat;
        @(negedge clk);
        req[t]              = 1'b1;
        op[2*t +: 2]        = o;
        acct[2*t +: 2]      = 2'(a);
        amount[5*t +: 5]    = 5'(amt);
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                req[t]           = 1'b0;
                op[2*t +: 2]     = 2'b00;
                acct[2*t +: 2]   = ~2'(a);
                amount[5*t +: 5] = 5'd0;
            end
            if (ack != 4'b0) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_ack"}, ack, 32'(4'b1 << t));
        chk({tag, "_st"}, rsp_status, es);
        chk({tag, "_bal"}, rsp_balance, eb);
        @(posedge clk);
        #1;
        chk({tag, "_ack0"}, ack, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int n;
        int last;
        int exp_bal[4];
        rst    = 1'b1;
        req    = '0;
        op     = '0;
        acct   = '0;
        amount = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_st", rsp_status, 0);
        chk("rst_bal", rsp_balance, 0);
        chk("rst_busy", busy, 0);
`ifdef LEDGER_AUDIT_EN
        chk("rst_cnt", txn_count, 0);
        chk("rst_err", err_sticky, 0);
`endif
        rst = 1'b0;

        do_txn(1, 2'b01, 2, 7, 2'b00, 7, "dep7");
        do_txn(1, 2'b11, 2, 0, 2'b00, 7, "q2");

        do_txn(0, 2'b01, 0, 5, 2'b00, 5, "dep5");
        do_txn(0, 2'b10, 0, 6, 2'b01, 5, "wd6");
        do_txn(0, 2'b10, 0, 5, 2'b00, 0, "wd5");

        for (int k = 1; k <= 8; k++) begin
            do_txn(2, 2'b01, 3, 31, 2'b00, 31 * k, "fill");
        end
        do_txn(2, 2'b01, 3, 2, 2'b00, 250, "fill2");
        do_txn(2, 2'b01, 3, 10, 2'b10, 250, "ovf");
        do_txn(2, 2'b01, 3, 5, 2'b00, 255, "max");

        do_txn(3, 2'b00, 3, 4, 2'b11, 255, "op00");
        do_txn(1, 2'b01, 2, 0, 2'b11, 7, "amt0");
        do_txn(0, 2'b10, 0, 0, 2'b11, 0, "wamt0");
        do_txn(3, 2'b11, 3, 0, 2'b00, 255, "q3");

        // All four terminals contend; pointer is at 3 so terminal 0 leads.
        exp_bal = '{0, 0, 7, 255};
        @(negedge clk);
        req    = 4'hF;
        op     = 8'hFF;
        acct   = 8'hE4;
        amount = '0;
        n      = 0;
        last   = 0;
        for (int c = 1; c <= 30 && n < 5; c++) begin
            @(posedge clk);
            #1;
            if (ack != 4'b0) begin
                chk("rr_ack", ack, 32'(4'b1 << (n % 4)));
                chk("rr_bal", rsp_balance, exp_bal[n % 4]);
                chk("rr_st", rsp_status, 0);
                if (n > 0) chk("rr_gap", c - last, 3);
                last = c;
                n++;
            end
        end
        req = '0;
        chk("rr_count", n, 5);
        @(posedge clk);
        #1;

        @(negedge clk);
        req[1]      = 1'b1;
        op[3:2]     = 2'b01;
        acct[3:2]   = 2'd1;
        amount[9:5] = 5'd9;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ack", ack, 0);
        chk("abort_idle", busy, 0);
        rst = 1'b0;
        req = '0;
        @(posedge clk);
        #1;
        chk("abort_ack2", ack, 0);
        do_txn(1, 2'b11, 1, 0, 2'b00, 0, "abort_q1");
        do_txn(2, 2'b11, 3, 0, 2'b00, 0, "abort_q3");

`ifdef LEDGER_AUDIT_EN
        chk("aud_cnt0", txn_count, 0);
        chk("aud_err0", err_sticky, 0);
        do_txn(0, 2'b01, 0, 3, 2'b00, 3, "a_dep3");
        do_txn(0, 2'b01, 0, 4, 2'b00, 7, "a_dep4");
        do_txn(0, 2'b01, 0, 5, 2'b00, 12, "a_dep5");
        chk("aud_err_pre", err_sticky, 0);
        do_txn(0, 2'b10, 0, 20, 2'b01, 12, "a_wd20");
        chk("aud_cnt", txn_count, 3);
        chk("aud_err", err_sticky, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("aud_cnt_rst", txn_count, 0);
        chk("aud_err_rst", err_sticky, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
